// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter/sequencer for the fetch and load/store paths of the multi-cycle RV32 core.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-break (default: data wins ties).
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_done,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_done,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_d;
    logic [TMO_W-1:0]  wdog;
    logic [TMO_W:0]    wdog_inc;
    logic              tmo_hit;
    logic              any_req;
    logic              pick_d;

    assign any_req  = i_req | d_req;
    assign wdog_inc = {1'b0, wdog} + {{TMO_W{1'b0}}, 1'b1};
    // Abort on the edge that would complete the TIMEOUT-th busy cycle.
    assign tmo_hit  = (TIMEOUT != 0) && (wdog_inc == (TMO_W+1)'(TIMEOUT));

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    always_comb begin
        pick_d = d_req & (~i_req | ~last_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_d <= pick_d;
        end
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = pick_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // All outputs below decode flops only; no input reaches an output combinationally.
    assign busy    = (state != IDLE);
    assign mem_req = (state == BUSY_I) || (state == BUSY_D);
    assign i_done  = (state == RESP) && !owner_d;
    assign d_done  = (state == RESP) && owner_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d   <= 1'b0;
            wdog      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            i_rdata   <= '0;
            i_err     <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d <= pick_d;
                        wdog    <= '0;
                        if (pick_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_we ? d_wdata : '0;
                            mem_wstrb <= d_we ? d_wstrb : {STRB_W{1'b0}};
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                BUSY_I: begin
                    wdog <= wdog_inc[TMO_W-1:0];
                    if (mem_ready) begin
                        i_rdata <= mem_rdata;
                        i_err   <= 1'b0;
                    end else if (tmo_hit) begin
                        i_rdata <= '0;
                        i_err   <= 1'b1;
                    end
                end
                BUSY_D: begin
                    wdog <= wdog_inc[TMO_W-1:0];
                    if (mem_ready) begin
                        d_rdata <= mem_we ? '0 : mem_rdata;
                        d_err   <= 1'b0;
                    end else if (tmo_hit) begin
                        d_rdata <= '0;
                        d_err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the multi-cycle RV32 core. The instruction-fetch path and the load/store path each present a level request; the block grants one at a time, drives the memory port from registered copies of the granted request, and waits for the memory's ready. It then returns read data, a one-cycle done pulse and an error flag to the owner. It sits between the control unit / PC logic and the unified memory, replacing separate instruction and data memory ports.

## Interface
- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width; byte strobes are DATA_W/8 bits
- TIMEOUT, 255, maximum cycles in a busy state before abort; 0 disables the watchdog
- TMO_W, 8, width of the watchdog counter; must satisfy TIMEOUT < 2^TMO_W
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level; held until i_done
- i_addr  in  ADDR_W  fetch address
- i_done  out  1  one-cycle completion pulse for a fetch
- i_rdata  out  DATA_W  fetch data; valid while i_done=1
- i_err  out  1  fetch timed out; valid while i_done=1
- d_req  in  1  data request, level; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_done  out  1  one-cycle completion pulse for a data access
- d_rdata  out  DATA_W  load data; valid while d_done=1; 0 for stores
- d_err  out  1  data access timed out; valid while d_done=1
- mem_req  out  1  memory transaction active
- mem_we  out  1  write enable; always 0 for fetches
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_wstrb  out  DATA_W/8  byte enables; all zeros for reads
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- **IDLE**
  - If no request is active, stay in IDLE.
  - If exactly one of i_req/d_req is high, go to that requester's BUSY state.
  - If both are high, apply the tie-break policy (see Configuration).
  - On entry to BUSY, latch the owner's addr, we, wdata and wstrb into the mem_* registers, set mem_req=1 and clear the watchdog.
- **BUSY_x**
  - mem_* outputs hold constant; later changes on the requester's inputs are ignored.
  - On mem_ready=1: capture mem_rdata (forced to 0 for stores), set err=0, drop mem_req, go to RESP.
  - If TIMEOUT≠0 and the watchdog reaches TIMEOUT with mem_ready still 0: go to RESP with rdata=0 and err=1, and drop mem_req.
- **RESP**
  - Assert the owner's done for exactly one cycle; the other requester's done stays 0.
  - Then go to IDLE.
- If a requester drops req during BUSY, the transaction still completes and done still pulses.
- Requester contract: drop req in the cycle after done is seen, or issue the next request. A req still high in IDLE starts a new transaction; this is legal back-to-back.
- mem_ready while mem_req=0 is ignored.
- Reset mid-transaction abandons the access and returns all state to reset values. No done pulse is generated.

## Timing
- Reset values:
  - State IDLE, all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, i_/d_done, i_/d_rdata, i_/d_err, busy).
  - Round-robin pointer set to "last=I".
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency:
  - Request sampled high at edge E: mem_req=1 from E+1.
  - mem_ready sampled high at edge E+k (k≥1): done=1 during the cycle after E+k.
  - Minimum request-to-done latency is 2 cycles; back-to-back throughput is one access per 3 cycles with zero-wait memory.
- Watchdog: counts busy cycles. Abort occurs at the edge where the count equals TIMEOUT, so mem_req is high for exactly TIMEOUT cycles. If mem_ready is high at that same edge, the transfer completes normally (ready wins).

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: simultaneous requests in IDLE are granted to the requester not granted most recently. The pointer updates on every grant.
  - Undefined: d_req always wins a tie (fixed data priority). The pointer logic is removed.

## Test plan
- Single fetch: i_req=1, i_addr=0x100; mem_ready high 3 cycles after mem_req rises with mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0; i_done pulses once with i_rdata=0x00500093, i_err=0; d_done stays 0.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0x3; zero-wait memory -> mem_wstrb=0x3 held until ready; d_done arrives 2 cycles after the request sample, with d_rdata=0.
- Tie, macro undefined: i_req and d_req rise together, 3 rounds -> every tie granted to data. Macro defined: after reset, grants are D, I, D.
- Timeout with TIMEOUT=4: fetch with mem_ready stuck 0 -> mem_req high exactly 4 cycles, then i_done=1, i_err=1, i_rdata=0; busy returns to 0.
- Reset mid-BUSY_D: assert rst asynchronously 2 cycles into a load -> all outputs 0 immediately; no d_done; a later fetch completes normally.
- Input change during busy: change d_addr from 0x40 to 0x80 while in BUSY_D -> mem_addr stays 0x40 until done.
